// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial interconnect: slave FSM state encoding,
// frame bit constants and default widths.
package serial_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_MODE       = 4'd1,
        ST_ADDR       = 4'd2,
        ST_WDATA      = 4'd3,
        ST_PARITY     = 4'd4,
        ST_MEM        = 4'd5,
        ST_RSP_START  = 4'd6,
        ST_RSP_STATUS = 4'd7,
        ST_RSP_DATA   = 4'd8
    } state_t;

    localparam logic START_BIT   = 1'b1;
    localparam logic MODE_WRITE  = 1'b1;
    localparam logic MODE_READ   = 1'b0;
    localparam logic STATUS_ACK  = 1'b1;
    localparam logic STATUS_NACK = 1'b0;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/slave_tx_ser.sv
// Response serialiser: on load drives the start bit, then status and
// (optionally) DATA_W data bits MSB first; done marks the last bit on the line.
module slave_tx_ser
    import serial_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              status,
    input  logic              has_data,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              done
);

    localparam int CW = $clog2(DATA_W + 2);

    logic [DATA_W:0] shift_reg;
    logic [CW-1:0]   left_reg;
    logic            active_reg;
    logic            tx_reg;

    // left_reg counts the bits still to follow the one currently on tx
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            left_reg   <= '0;
            active_reg <= 1'b0;
            tx_reg     <= 1'b0;
        end else if (load) begin
            tx_reg     <= START_BIT;
            shift_reg  <= {status, data};
            left_reg   <= has_data ? CW'(DATA_W + 1) : CW'(1);
            active_reg <= 1'b1;
        end else if (active_reg) begin
            if (left_reg == '0) begin
                tx_reg     <= 1'b0;
                active_reg <= 1'b0;
            end else begin
                tx_reg    <= shift_reg[DATA_W];
                shift_reg <= {shift_reg[DATA_W-1:0], 1'b0};
                left_reg  <= left_reg - CW'(1);
            end
        end
    end

    assign tx   = tx_reg;
    assign done = active_reg && (left_reg == '0);

endmodule

// File: rtl/slave_port.sv
// Serial-bus slave endpoint: deserialises a request frame, performs one
// req/ack memory access, and returns the response. Optional SLAVE_PARITY_EN.
module slave_port
    import serial_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              tx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [3:0]        state_o
);

    localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int BW   = $clog2(MAXW + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

`ifdef SLAVE_PARITY_EN
    localparam state_t REQ_END = ST_PARITY;
`else
    localparam state_t REQ_END = ST_MEM;
`endif

    state_t            state_reg, state_next;
    logic [BW-1:0]     bit_cnt_reg;
    logic [TW-1:0]     tout_cnt_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
`ifdef SLAVE_PARITY_EN
    logic              parity_reg;
`endif

    logic ser_load, ser_status, ser_has_data, ser_done;

    always_comb begin
        state_next   = state_reg;
        ser_load     = 1'b0;
        ser_status   = STATUS_NACK;
        ser_has_data = 1'b0;
        case (state_reg)
            ST_IDLE:  if (rx == START_BIT) state_next = ST_MODE;
            ST_MODE:  state_next = ST_ADDR;
            ST_ADDR: begin
                if (bit_cnt_reg == BW'(ADDR_W - 1))
                    state_next = (mem_we_reg == MODE_WRITE) ? ST_WDATA : REQ_END;
            end
            ST_WDATA: begin
                if (bit_cnt_reg == BW'(DATA_W - 1))
                    state_next = REQ_END;
            end
`ifdef SLAVE_PARITY_EN
            ST_PARITY: begin
                // Even parity: mode, address, data and parity bit XOR to zero
                if ((parity_reg ^ rx) == 1'b0) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_RSP_START;
                    ser_load   = 1'b1;
                end
            end
`endif
            ST_MEM: begin
                // An ack arriving in the final timeout cycle still counts
                if (mem_ack) begin
                    state_next   = ST_RSP_START;
                    ser_load     = 1'b1;
                    ser_status   = STATUS_ACK;
                    ser_has_data = (mem_we_reg == MODE_READ);
                end else if (tout_cnt_reg == TW'(TIMEOUT - 1)) begin
                    state_next = ST_RSP_START;
                    ser_load   = 1'b1;
                end
            end
            ST_RSP_START:  state_next = ST_RSP_STATUS;
            ST_RSP_STATUS: state_next = ser_done ? ST_IDLE : ST_RSP_DATA;
            ST_RSP_DATA:   if (ser_done) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            tout_cnt_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
`ifdef SLAVE_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;

            if (state_next != state_reg)
                bit_cnt_reg <= '0;
            else if (state_reg == ST_ADDR || state_reg == ST_WDATA)
                bit_cnt_reg <= bit_cnt_reg + BW'(1);

            if (state_reg == ST_MEM && state_next == ST_MEM)
                tout_cnt_reg <= tout_cnt_reg + TW'(1);
            else
                tout_cnt_reg <= '0;

            // Address/data shift straight into the access registers
            case (state_reg)
                ST_MODE: begin
                    mem_we_reg <= (rx == MODE_WRITE);
`ifdef SLAVE_PARITY_EN
                    parity_reg <= rx;
`endif
                end
                ST_ADDR: begin
                    mem_addr_reg <= {mem_addr_reg[ADDR_W-2:0], rx};
`ifdef SLAVE_PARITY_EN
                    parity_reg   <= parity_reg ^ rx;
`endif
                end
                ST_WDATA: begin
                    mem_wdata_reg <= {mem_wdata_reg[DATA_W-2:0], rx};
`ifdef SLAVE_PARITY_EN
                    parity_reg    <= parity_reg ^ rx;
`endif
                end
                default: ;
            endcase
        end
    end

    slave_tx_ser #(.DATA_W(DATA_W)) u_tx_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .status   (ser_status),
        .has_data (ser_has_data),
        .data     (mem_rdata),
        .tx       (tx),
        .done     (ser_done)
    );

    assign mem_req   = (state_reg == ST_MEM);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign state_o   = state_reg;

endmodule

// File: doc/slave_port.md
# slave_port

Serial-bus slave endpoint: the responder end of the master/arbiter/decoder serial interconnect. Deserialises request frames arriving on `rx`, issues one parallel access to a local register/memory through a req/ack handshake, and serialises the response frame back on `tx`. One instance sits behind each slave leg of the bus (s1..s3 rx/tx pair).

## Interface
- `ADDR_W`, 12: slave-local address bits carried in the frame (MSB first)
- `DATA_W`, 8: data bits per frame (MSB first)
- `TIMEOUT`, 255: cycles to wait for `mem_ack` before answering NACK; ≥1
- `clk`  in  1  bus clock
- `rst`  in  1  synchronous, active-high reset
- `rx`  in  1  serial request from bus (bus-side `sN_rx`)
- `tx`  out  1  serial response to bus (bus-side `sN_tx`)
- `mem_req`  out  1  access request, held until `mem_ack` or timeout
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`
- `mem_addr`  out  ADDR_W  access address
- `mem_wdata`  out  DATA_W  write data
- `mem_ack`  in  1  access complete, single-cycle pulse
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `busy`  out  1  high in any state other than IDLE
- `state_o`  out  4  current FSM state encoding, debug only

## Operation
- Line idle level 0 on both `rx` and `tx`; one bit per `clk`, sampled every rising edge.
- Request frame: start(1), mode(1=write,0=read), ADDR_W address bits, [write only] DATA_W data bits, [SLAVE_PARITY_EN only] parity bit.
- Response frame: start(1), status(1=ACK,0=NACK), [read ACK only] DATA_W data bits. NACK read sends no data.
- States: IDLE, MODE, ADDR, WDATA, PARITY, MEM, RSP_START, RSP_STATUS, RSP_DATA.
- IDLE→MODE when `rx`=1. MODE latches mode. ADDR shifts ADDR_W bits (bit counter). ADDR→WDATA on write, else →PARITY/MEM. WDATA shifts DATA_W bits. PARITY compares. MEM holds `mem_req`.
- MEM exits on `mem_ack` (ACK; read latches `mem_rdata`) or timeout counter reaching TIMEOUT (NACK, `mem_req` dropped). `mem_ack` in the timeout cycle wins: ACK.
- RSP_START drives 1; RSP_STATUS drives status; RSP_DATA shifts DATA_W bits; then IDLE with `tx`=0.
- `rx` ignored from MEM until return to IDLE (half-duplex); a stray 1 during response does not start a frame.
- `mem_ack` outside MEM ignored.
- Reset mid-frame: partial frame discarded, no memory access issued, no response sent.

## Timing
- Reset values: `tx`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `state_o`=IDLE (0).
- Start bit sampled at cycle 0; last request bit at cycle 1+ADDR_W(+DATA_W)(+1 parity).
- `mem_req` rises the cycle after the last request bit; `mem_addr/we/wdata` stable while high; falls the cycle after `mem_ack`.
- `tx` start bit on the cycle after `mem_ack` (registered output); status next cycle; data following, MSB first.
- Timeout: `mem_req` high for exactly TIMEOUT cycles, then NACK start bit next cycle.
- Minimum turnaround: new request accepted the cycle after last response bit.

## Configuration
- `SLAVE_PARITY_EN` defined: request carries even parity over mode, address, data bits; PARITY state checks it. Mismatch → skip MEM (no `mem_req`), respond NACK immediately.
- Undefined: no parity bit, PARITY state never entered, ADDR/WDATA go straight to MEM.

## Structure
- Shared package `serial_bus_pkg`: state enum (4-bit encoding), frame constants (START_BIT, MODE_WRITE/READ, STATUS_ACK/NACK), default widths.
- One sub-module, `slave_tx_ser`: loads status + data, shifts the response frame out, signals done; FSM in `slave_port` starts it.

## Test plan
- Write addr 0x0A5, data 0x3C, `mem_ack` 2 cycles after `mem_req` → `mem_we`=1, `mem_addr`=0x0A5, `mem_wdata`=0x3C; `tx` = 1,1 then idle.
- Read addr 0xFFF, `mem_rdata`=0xA5 with immediate ack → `tx` = 1,1,10100101 MSB first.
- Read, `mem_ack` never arrives, TIMEOUT=4 → `mem_req` high 4 cycles, `tx` = 1,0, no data bits.
- `mem_ack` in the TIMEOUT-th cycle → ACK response, rdata returned.
- `rst` asserted mid-ADDR → next cycle IDLE, `tx`=0, `mem_req` never rises; next full frame processed normally.
- SLAVE_PARITY_EN, write with flipped parity bit → no `mem_req`, `tx` = 1,0.
